// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands and control from ID and presents them to EX.
// Inserts a bubble on a load-use hazard or a taken branch/jump flush.
// Freezes completely while MEM reports an external stall.
// Optional: define ID_EX_PERF_CNT_EN to add saturating bubble/flush counters.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_id,
   input  logic [XLEN-1:0] pc_id,
   input  logic [XLEN-1:0] rs1_data_id,
   input  logic [XLEN-1:0] rs2_data_id,
   input  logic [XLEN-1:0] imm_id,
   input  logic [4:0]      rs1_id,
   input  logic [4:0]      rs2_id,
   input  logic [4:0]      rd_id,
   input  logic            uses_rs1_id,
   input  logic            uses_rs2_id,
   input  logic [3:0]      alu_op_id,
   input  logic            alu_src_id,
   input  logic            mem_read_id,
   input  logic            mem_write_id,
   input  logic            reg_write_id,
   input  logic            mem_to_reg_id,
   input  logic            flush_ex,
   input  logic            stall_ext,
   output logic            stall_if_id,
   output logic            valid_ex,
   output logic [XLEN-1:0] pc_ex,
   output logic [XLEN-1:0] rs1_data_ex,
   output logic [XLEN-1:0] rs2_data_ex,
   output logic [XLEN-1:0] imm_ex,
   output logic [4:0]      rs1_ex,
   output logic [4:0]      rs2_ex,
   output logic [4:0]      rd_ex,
   output logic [3:0]      alu_op_ex,
   output logic            alu_src_ex,
   output logic            mem_read_ex,
   output logic            mem_write_ex,
   output logic            reg_write_ex,
   output logic            mem_to_reg_ex
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]     bubble_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            alu_src;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            mem_to_reg;
   } ex_t;

   ex_t  ex_q, ex_d, ld;
   logic lu;

   // Load-use hazard, evaluated only against the registered EX instruction.
   always_comb begin
      lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & valid_id &
           ((uses_rs1_id & (rs1_id == ex_q.rd)) | (uses_rs2_id & (rs2_id == ex_q.rd)));
   end

   // Hold upstream on a memory freeze or a non-squashed load-use; quiet in reset.
   always_comb begin
      stall_if_id = rst_n & (stall_ext | (~flush_ex & lu));
   end

   // Capture image of ID; an empty slot carries no control and no indices.
   always_comb begin
      ld          = '0;
      ld.valid    = valid_id;
      ld.pc       = pc_id;
      ld.rs1_data = rs1_data_id;
      ld.rs2_data = rs2_data_id;
      ld.imm      = imm_id;
      if (valid_id) begin
         ld.rs1        = rs1_id;
         ld.rs2        = rs2_id;
         ld.rd         = rd_id;
         ld.alu_op     = alu_op_id;
         ld.alu_src    = alu_src_id;
         ld.mem_read   = mem_read_id;
         ld.mem_write  = mem_write_id;
         ld.reg_write  = reg_write_id;
         ld.mem_to_reg = mem_to_reg_id;
      end
   end

   // Priority: freeze, then flush bubble, then load-use bubble, then load.
   always_comb begin
      ex_d = ld;
      if (stall_ext)
         ex_d = ex_q;
      else if (flush_ex || lu)
         ex_d = '0;
   end

   // ID/EX register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

`ifdef ID_EX_PERF_CNT_EN
   // Saturating event counters; frozen together with the pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!stall_ext) begin
         if (flush_ex) begin
            if (flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
         end else if (lu) begin
            if (bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

   assign valid_ex      = ex_q.valid;
   assign pc_ex         = ex_q.pc;
   assign rs1_data_ex   = ex_q.rs1_data;
   assign rs2_data_ex   = ex_q.rs2_data;
   assign imm_ex        = ex_q.imm;
   assign rs1_ex        = ex_q.rs1;
   assign rs2_ex        = ex_q.rs2;
   assign rd_ex         = ex_q.rd;
   assign alu_op_ex     = ex_q.alu_op;
   assign alu_src_ex    = ex_q.alu_src;
   assign mem_read_ex   = ex_q.mem_read;
   assign mem_write_ex  = ex_q.mem_write;
   assign reg_write_ex  = ex_q.reg_write;
   assign mem_to_reg_ex = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for the ID/EX register and hazard logic.
// Counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_id;
   logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
   logic [4:0]  rs1_id, rs2_id, rd_id;
   logic        uses_rs1_id, uses_rs2_id;
   logic [3:0]  alu_op_id;
   logic        alu_src_id, mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id;
   logic        flush_ex, stall_ext;
   logic        stall_if_id, valid_ex;
   logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
   logic [4:0]  rs1_ex, rs2_ex, rd_ex;
   logic [3:0]  alu_op_ex;
   logic        alu_src_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt, flush_cnt;
   logic [31:0] b0, f0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
      .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .alu_op_id(alu_op_id),
      .alu_src_id(alu_src_id), .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
      .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
      .flush_ex(flush_ex), .stall_ext(stall_ext), .stall_if_id(stall_if_id),
      .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
      .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .rd_ex(rd_ex), .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex),
      .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
      .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in ID.
   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic mr, input logic rw);
      valid_id = v; pc_id = pc; rs1_id = r1; rs2_id = r2; rd_id = rd;
      uses_rs1_id = u1; uses_rs2_id = u2; mem_read_id = mr; reg_write_id = rw;
      mem_to_reg_id = mr; alu_src_id = mr; mem_write_id = 1'b0;
      alu_op_id = 4'h3; imm_id = 32'h0000_0004;
      rs1_data_id = pc ^ 32'h1111_0000; rs2_data_id = pc ^ 32'h2222_0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush_ex = 1'b0; stall_ext = 1'b1;
      set_id(1'b1, 32'hDEAD_BEEF, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(); tick();
      checks++;
      if ({valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex, alu_op_ex,
           alu_src_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex} !== '0) begin
         errors++; $display("FAIL reset_outputs: valid_ex=%0d pc_ex=%h rd_ex=%0d, required all zero",
                            valid_ex, pc_ex, rd_ex);
      end
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL reset_stall: stall_if_id=%0d, required 0", stall_if_id);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_cnt: bubble=%0d flush=%0d, required 0/0", bubble_cnt, flush_cnt);
      end
`endif
      stall_ext = 1'b0; rst_n = 1'b1;
      set_id(1'b1, 32'h0000_0100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checks++;
      if (pc_ex !== 32'h100 || valid_ex !== 1'b1 || rd_ex !== 5'd3 || reg_write_ex !== 1'b1) begin
         errors++; $display("FAIL first_load: pc_ex=%h valid_ex=%0d rd_ex=%0d, required 100/1/3",
                            pc_ex, valid_ex, rd_ex);
      end
   endtask

   task automatic test_invalid_load();
      set_id(1'b0, 32'h0000_0180, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (valid_ex !== 1'b0 || rd_ex !== 5'd0 || rs1_ex !== 5'd0 || mem_read_ex !== 1'b0 ||
          reg_write_ex !== 1'b0 || alu_op_ex !== 4'd0) begin
         errors++; $display("FAIL invalid_load: valid=%0d rd=%0d rs1=%0d mr=%0d rw=%0d op=%0d, required zeros",
                            valid_ex, rd_ex, rs1_ex, mem_read_ex, reg_write_ex, alu_op_ex);
      end
   endtask

   task automatic test_load_use();
`ifdef ID_EX_PERF_CNT_EN
      b0 = bubble_cnt;
`endif
      set_id(1'b1, 32'h0000_0200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1); // lw x5
      tick();
      set_id(1'b1, 32'h0000_0204, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1); // add x6,x5,x1
      #1;
      checks++;
      if (stall_if_id !== 1'b1) begin
         errors++; $display("FAIL lu_stall: stall_if_id=%0d, required 1", stall_if_id);
      end
      tick();
      checks++;
      if (valid_ex !== 1'b0 || rd_ex !== 5'd0 || mem_read_ex !== 1'b0 || pc_ex !== 32'd0) begin
         errors++; $display("FAIL lu_bubble: valid=%0d rd=%0d mr=%0d pc=%h, required 0/0/0/0",
                            valid_ex, rd_ex, mem_read_ex, pc_ex);
      end
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL lu_release: stall_if_id=%0d, required 0", stall_if_id);
      end
      tick();
      checks++;
      if (valid_ex !== 1'b1 || rs1_ex !== 5'd5 || rd_ex !== 5'd6 || pc_ex !== 32'h204) begin
         errors++; $display("FAIL lu_reload: valid=%0d rs1=%0d rd=%0d pc=%h, required 1/5/6/204",
                            valid_ex, rs1_ex, rd_ex, pc_ex);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (bubble_cnt !== b0 + 32'd1) begin
         errors++; $display("FAIL lu_count: bubble_cnt=%0d, required %0d", bubble_cnt, b0 + 32'd1);
      end
`endif
   endtask

   task automatic test_no_false_stall();
      set_id(1'b1, 32'h0000_0300, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); // lw x0
      tick();
      set_id(1'b1, 32'h0000_0304, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL x0_load: stall_if_id=%0d, required 0", stall_if_id);
      end
      set_id(1'b1, 32'h0000_0308, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1); // lw x8
      tick();
      set_id(1'b1, 32'h0000_030C, 5'd3, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1); // rs2==rd, unused
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL unused_rs2: stall_if_id=%0d, required 0", stall_if_id);
      end
      tick();
      checks++;
      if (valid_ex !== 1'b1 || pc_ex !== 32'h30C || rd_ex !== 5'd9) begin
         errors++; $display("FAIL unused_rs2_load: valid=%0d pc=%h rd=%0d, required 1/30c/9",
                            valid_ex, pc_ex, rd_ex);
      end
   endtask

   task automatic test_flush_over_lu();
`ifdef ID_EX_PERF_CNT_EN
      b0 = bubble_cnt; f0 = flush_cnt;
`endif
      set_id(1'b1, 32'h0000_0400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 32'h0000_0404, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
      flush_ex = 1'b1;
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL flush_stall: stall_if_id=%0d, required 0", stall_if_id);
      end
      tick();
      flush_ex = 1'b0;
      checks++;
      if (valid_ex !== 1'b0 || rd_ex !== 5'd0 || pc_ex !== 32'd0) begin
         errors++; $display("FAIL flush_bubble: valid=%0d rd=%0d pc=%h, required 0/0/0",
                            valid_ex, rd_ex, pc_ex);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (flush_cnt !== f0 + 32'd1 || bubble_cnt !== b0) begin
         errors++; $display("FAIL flush_count: flush=%0d bubble=%0d, required %0d/%0d",
                            flush_cnt, bubble_cnt, f0 + 32'd1, b0);
      end
`endif
   endtask

   task automatic test_hold();
      set_id(1'b1, 32'h0000_0500, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
`ifdef ID_EX_PERF_CNT_EN
      b0 = bubble_cnt; f0 = flush_cnt;
`endif
      stall_ext = 1'b1; flush_ex = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 32'h0000_0600 + 32'(i * 4), 5'd12, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1);
         #1;
         checks++;
         if (stall_if_id !== 1'b1) begin
            errors++; $display("FAIL hold_stall[%0d]: stall_if_id=%0d, required 1", i, stall_if_id);
         end
         tick();
         checks++;
         if (valid_ex !== 1'b1 || pc_ex !== 32'h500 || rd_ex !== 5'd12 || mem_read_ex !== 1'b0) begin
            errors++; $display("FAIL hold_state[%0d]: valid=%0d pc=%h rd=%0d mr=%0d, required 1/500/12/0",
                               i, valid_ex, pc_ex, rd_ex, mem_read_ex);
         end
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (flush_cnt !== f0 || bubble_cnt !== b0) begin
         errors++; $display("FAIL hold_count: flush=%0d bubble=%0d, required %0d/%0d",
                            flush_cnt, bubble_cnt, f0, b0);
      end
`endif
      stall_ext = 1'b0;
      tick();
      flush_ex = 1'b0;
      checks++;
      if (valid_ex !== 1'b0 || pc_ex !== 32'd0 || rd_ex !== 5'd0) begin
         errors++; $display("FAIL hold_release: valid=%0d pc=%h rd=%0d, required 0/0/0",
                            valid_ex, pc_ex, rd_ex);
      end
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 32'h0000_0700, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      stall_ext = 1'b1; flush_ex = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (valid_ex !== 1'b0 || pc_ex !== 32'd0 || stall_if_id !== 1'b0) begin
         errors++; $display("FAIL async_reset: valid=%0d pc=%h stall=%0d, required 0/0/0",
                            valid_ex, pc_ex, stall_if_id);
      end
      tick();
      rst_n = 1'b1; stall_ext = 1'b0; flush_ex = 1'b0;
      set_id(1'b1, 32'h0000_0710, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checks++;
      if (valid_ex !== 1'b1 || pc_ex !== 32'h710 || rd_ex !== 5'd4) begin
         errors++; $display("FAIL post_reset_load: valid=%0d pc=%h rd=%0d, required 1/710/4",
                            valid_ex, pc_ex, rd_ex);
      end
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_saturation();
      force dut.bubble_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_cnt;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 32'h0000_0800, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
         tick();
         set_id(1'b1, 32'h0000_0804, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
         tick();
      end
      checks++;
      if (bubble_cnt !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL saturation: bubble_cnt=%h, required ffffffff", bubble_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_invalid_load();
      test_load_use();
      test_no_false_stall();
      test_flush_over_lu();
      test_hold();
      test_reset_mid_stall();
`ifdef ID_EX_PERF_CNT_EN
      test_saturation();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
